// File: rtl/frame_buf_pkg.sv
// Shared types and defaults for the double-buffered interpolation frame store.
package frame_buf_pkg;

  localparam int PIX_W_DEF = 24;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WAIT_SWAP
  } state_e;

endpackage

// File: rtl/frame_bank.sv
// One frame bank: simple dual-port RAM with a write port and a registered read port.
module frame_bank #(
  parameter int PIX_W  = 24,
  parameter int DEPTH  = 16384,
  parameter int ADDR_W = 14,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data
);

  logic [PIX_W-1:0] mem [DEPTH];
  logic [PIX_W-1:0] rd_data_q;
  logic [PIX_W-1:0] rd_data_d;
  logic             rd_in_range;

  // Addresses past the end of the frame read back as black rather than aliasing.
  assign rd_in_range = ({1'b0, rd_addr} < (ADDR_W + 1)'(DEPTH));

  always_comb begin
    rd_data_d = '0;
    if (rd_in_range) rd_data_d = mem[rd_addr[IDX_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/interp_frame_buffer.sv
// Double-buffered frame store: fills the back bank in raster order and swaps banks at vertical sync.
module interp_frame_buffer
  import frame_buf_pkg::*;
#(
  parameter int PIX_W  = PIX_W_DEF,
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        pos_cursor,
  input  logic              in_valid,
  input  logic [PIX_W-1:0]  in_pixel,
  output logic              in_ready,
  input  logic              frame_sync,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data,
  output logic              frame_ready,
  output logic              fill_busy,
  output logic              restart
);

  localparam int DEPTH = IMG_W * IMG_H;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [3:0]       cursor_q, cursor_d;
  logic             disp_bank_q, disp_bank_d;
  logic             frame_ready_q, frame_ready_d;
  logic             restart_q, restart_d;
  logic             wr_en;
  logic             cursor_change;
  logic [PIX_W-1:0] rd_data0, rd_data1;

  assign cursor_change = (pos_cursor != cursor_q) && (state_q != IDLE);

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    cursor_d      = cursor_q;
    disp_bank_d   = disp_bank_q;
    frame_ready_d = frame_ready_q;
    restart_d     = 1'b0;
    wr_en         = 1'b0;

    unique case (state_q)
      IDLE: begin
        cursor_d = pos_cursor;
        if (start) begin
          wr_ptr_d = '0;
          state_d  = FILL;
        end
      end
      FILL: begin
        if (in_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (wr_ptr_q == LAST_PTR) begin
            wr_ptr_d = '0;
            state_d  = WAIT_SWAP;
          end
        end
      end
      WAIT_SWAP: begin
        if (frame_sync) begin
          disp_bank_d   = ~disp_bank_q;
          frame_ready_d = 1'b1;
          wr_ptr_d      = '0;
          state_d       = FILL;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new quadrant overrides both completion and swap; the pixel in flight is still written.
    if (cursor_change) begin
      cursor_d      = pos_cursor;
      wr_ptr_d      = '0;
      state_d       = FILL;
      restart_d     = 1'b1;
      disp_bank_d   = disp_bank_q;
      frame_ready_d = frame_ready_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      cursor_q      <= '0;
      disp_bank_q   <= 1'b0;
      frame_ready_q <= 1'b0;
      restart_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      cursor_q      <= cursor_d;
      disp_bank_q   <= disp_bank_d;
      frame_ready_q <= frame_ready_d;
      restart_q     <= restart_d;
    end
  end

  frame_bank #(.PIX_W(PIX_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .IDX_W(PTR_W)) u_bank0 (
    .clk     (clk),
    .rst_n   (rst),
    .we      (wr_en & disp_bank_q),
    .wr_addr (wr_ptr_q),
    .wr_data (in_pixel),
    .rd_addr (rd_addr),
    .rd_data (rd_data0)
  );

  frame_bank #(.PIX_W(PIX_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .IDX_W(PTR_W)) u_bank1 (
    .clk     (clk),
    .rst_n   (rst),
    .we      (wr_en & ~disp_bank_q),
    .wr_addr (wr_ptr_q),
    .wr_data (in_pixel),
    .rd_addr (rd_addr),
    .rd_data (rd_data1)
  );

  assign rd_data     = disp_bank_q ? rd_data1 : rd_data0;
  assign in_ready    = (state_q == FILL);
  assign fill_busy   = (state_q == FILL);
  assign frame_ready = frame_ready_q;
  assign restart     = restart_q;

endmodule

// File: tb/tb_interp_frame_buffer.sv
// Directed self-checking bench for interp_frame_buffer on a 4x4 frame.
module tb_interp_frame_buffer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  pos_cursor;
  logic        in_valid;
  logic [23:0] in_pixel;
  logic        in_ready;
  logic        frame_sync;
  logic [4:0]  rd_addr;
  logic [23:0] rd_data;
  logic        frame_ready;
  logic        fill_busy;
  logic        restart;

  int checks = 0;
  int failures = 0;

  interp_frame_buffer #(.PIX_W(24), .IMG_W(4), .IMG_H(4), .ADDR_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pos_cursor  (pos_cursor),
    .in_valid    (in_valid),
    .in_pixel    (in_pixel),
    .in_ready    (in_ready),
    .frame_sync  (frame_sync),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_ready (frame_ready),
    .fill_busy   (fill_busy),
    .restart     (restart)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [23:0] pixel);
    in_valid = valid;
    in_pixel = pixel;
    tick();
  endtask

  task automatic readCheck(input string tag, input logic [4:0] addr, input logic [23:0] expected);
    rd_addr = addr;
    tick();
    checkOutput(tag, {8'h0, rd_data}, {8'h0, expected});
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    pos_cursor = 4'd0;
    in_valid = 1'b0;
    in_pixel = 24'h0;
    frame_sync = 1'b0;
    rd_addr = 5'd0;

    #12;
    checkOutput("reset_in_ready", {31'h0, in_ready}, 32'h0);
    checkOutput("reset_rd_data", {8'h0, rd_data}, 32'h0);
    checkOutput("reset_frame_ready", {31'h0, frame_ready}, 32'h0);
    checkOutput("reset_fill_busy", {31'h0, fill_busy}, 32'h0);
    checkOutput("reset_restart", {31'h0, restart}, 32'h0);
    rst = 1'b1;
    tick();

    checkOutput("idle_in_ready", {31'h0, in_ready}, 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("start_in_ready", {31'h0, in_ready}, 32'h1);
    checkOutput("start_fill_busy", {31'h0, fill_busy}, 32'h1);

    // Frame 1: back-to-back pixels 0x00000k
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, 24'(k));
      if (k == 14) checkOutput("f1_ready_before_last", {31'h0, in_ready}, 32'h1);
    end
    in_valid = 1'b0;
    checkOutput("f1_done_in_ready", {31'h0, in_ready}, 32'h0);
    checkOutput("f1_done_frame_ready", {31'h0, frame_ready}, 32'h0);
    checkOutput("f1_done_fill_busy", {31'h0, fill_busy}, 32'h0);
    tick();
    checkOutput("f1_wait_in_ready", {31'h0, in_ready}, 32'h0);

    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    checkOutput("swap1_frame_ready", {31'h0, frame_ready}, 32'h1);
    checkOutput("swap1_refill_in_ready", {31'h0, in_ready}, 32'h1);
    for (int a = 0; a < 16; a++) readCheck("f1_read", 5'(a), 24'(a));

    // Frame 2 with gaps; frame_sync and start during FILL must be ignored
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, 24'h100000 + 24'(k));
      in_valid = 1'b0;
      if (k == 5) begin
        frame_sync = 1'b1;
        start = 1'b1;
      end
      tick();
      frame_sync = 1'b0;
      start = 1'b0;
      if (k == 5) begin
        checkOutput("sync_in_fill_frame_ready", {31'h0, frame_ready}, 32'h1);
        checkOutput("sync_in_fill_busy", {31'h0, fill_busy}, 32'h1);
      end
    end
    checkOutput("f2_done_in_ready", {31'h0, in_ready}, 32'h0);
    readCheck("f2_pre_swap_a3", 5'd3, 24'h000003);
    readCheck("f2_pre_swap_a15", 5'd15, 24'h00000F);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    for (int a = 0; a < 16; a++) readCheck("f2_read", 5'(a), 24'h100000 + 24'(a));

    // Frame 3: cursor change after 7 transfers restarts at address 0
    for (int k = 0; k < 7; k++) applyStimulus(1'b1, 24'h200000 + 24'(k));
    in_valid = 1'b0;
    pos_cursor = 4'd5;
    tick();
    checkOutput("cursor_restart_pulse", {31'h0, restart}, 32'h1);
    checkOutput("cursor_restart_in_ready", {31'h0, in_ready}, 32'h1);
    tick();
    checkOutput("cursor_restart_single", {31'h0, restart}, 32'h0);
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, 24'h300000 + 24'(k));
      if (k == 14) checkOutput("f3_not_done_at_15", {31'h0, in_ready}, 32'h1);
    end
    in_valid = 1'b0;
    checkOutput("f3_done_in_ready", {31'h0, in_ready}, 32'h0);
    readCheck("f3_display_unchanged", 5'd0, 24'h100000);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    readCheck("f3_read_a0", 5'd0, 24'h300000);
    readCheck("f3_read_a7", 5'd7, 24'h300007);
    readCheck("f3_read_a15", 5'd15, 24'h30000F);

    // Frame 4: cursor change together with frame_sync in WAIT_SWAP
    for (int k = 0; k < 16; k++) applyStimulus(1'b1, 24'h400000 + 24'(k));
    in_valid = 1'b0;
    checkOutput("f4_wait_in_ready", {31'h0, in_ready}, 32'h0);
    pos_cursor = 4'd9;
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    checkOutput("cursor_vs_sync_restart", {31'h0, restart}, 32'h1);
    checkOutput("cursor_vs_sync_fill_busy", {31'h0, fill_busy}, 32'h1);
    checkOutput("cursor_vs_sync_frame_ready", {31'h0, frame_ready}, 32'h1);
    readCheck("cursor_vs_sync_no_swap", 5'd0, 24'h300000);
    readCheck("rd_addr_out_of_range", 5'd16, 24'h000000);

    // Asynchronous reset between edges during a fill
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 24'h500000 + 24'(k));
    rd_addr = 5'd2;
    tick();
    checkOutput("pre_reset_rd_data", {8'h0, rd_data}, 32'h300002);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_reset_in_ready", {31'h0, in_ready}, 32'h0);
    checkOutput("async_reset_rd_data", {8'h0, rd_data}, 32'h0);
    checkOutput("async_reset_frame_ready", {31'h0, frame_ready}, 32'h0);
    checkOutput("async_reset_fill_busy", {31'h0, fill_busy}, 32'h0);
    #1;
    rst = 1'b1;
    in_valid = 1'b1;
    tick();
    tick();
    checkOutput("post_reset_needs_start", {31'h0, in_ready}, 32'h0);
    checkOutput("post_reset_no_restart", {31'h0, restart}, 32'h0);
    in_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("post_reset_start", {31'h0, in_ready}, 32'h1);
    checkOutput("post_reset_frame_ready", {31'h0, frame_ready}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
